// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider: restoring division, one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and completes one cycle after acceptance.
module div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        div_valid,
   input  logic        div_signed,
   input  logic [31:0] div_src1,
   input  logic [31:0] div_src2,
   input  logic        div_cancel,
   output logic        div_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] div_quotient,
   output logic [31:0] div_remainder
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dsr_q, dsr_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] remo_q, remo_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;

   logic        accept;
   logic        fits;
   logic [32:0] trial;
   logic [32:0] diff;
   logic [31:0] q_next;
   logic [31:0] r_next;
   logic [31:0] src1_mag;
   logic [31:0] src2_mag;

   assign div_ready     = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign div_quotient  = quot_q;
   assign div_remainder = remo_q;

   always_comb begin
      accept   = div_valid & (state_q == IDLE) & ~div_cancel;
      src1_mag = (div_signed & div_src1[31]) ? -div_src1 : div_src1;
      src2_mag = (div_signed & div_src2[31]) ? -div_src2 : div_src2;

      // The dividend register doubles as the quotient shift register.
      trial  = {rem_q, dvd_q[31]};
      diff   = trial - {1'b0, dsr_q};
      fits   = (trial >= {1'b0, dsr_q});
      r_next = fits ? diff[31:0] : trial[31:0];
      q_next = {dvd_q[30:0], fits};

      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      dsr_d   = dsr_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               dvd_d   = src1_mag;
               dsr_d   = src2_mag;
               rem_d   = 32'd0;
               cnt_d   = 6'd0;
               // A zero divisor must yield all-ones, so its quotient is never negated.
               q_neg_d = div_signed & (div_src1[31] ^ div_src2[31]) & (|div_src2);
               r_neg_d = div_signed & div_src1[31];
               state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
               if (div_src2 == 32'd0) begin
                  state_d = DONE;
                  quot_d  = 32'hFFFF_FFFF;
                  remo_d  = div_src1;
               end
`endif
            end
         end
         CALC: begin
            dvd_d = q_next;
            rem_d = r_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               cnt_d   = 6'd0;
               quot_d  = q_neg_q ? -q_next : q_next;
               remo_d  = r_neg_q ? -r_next : r_next;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (div_cancel) begin
         state_d = IDLE;
         cnt_d   = 6'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         dvd_q   <= 32'd0;
         rem_q   <= 32'd0;
         dsr_q   <= 32'd0;
         quot_q  <= 32'd0;
         remo_q  <= 32'd0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         dsr_q   <= dsr_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, handshake/cancel/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_div_unit;

   logic        clk;
   logic        resetn;
   logic        div_valid;
   logic        div_signed;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        div_cancel;
   logic        div_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;

   int total;
   int bad;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 33;
`endif
   localparam int NORM_LAT = 33;

   typedef struct {
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   div_unit dut (
      .clk           (clk),
      .resetn        (resetn),
      .div_valid     (div_valid),
      .div_signed    (div_signed),
      .div_src1      (div_src1),
      .div_src2      (div_src2),
      .div_cancel    (div_cancel),
      .div_ready     (div_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Quotient truncates toward zero, remainder takes the dividend's sign; x/0 -> all-ones, x.
   function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, tq, tr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         tq = sa / sb;
         tr = sa % sb;
         q  = tq[31:0];
         r  = tr[31:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Presents one request at a negedge; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      div_valid  = 1'b1;
      div_signed = sgn;
      div_src1   = a;
      div_src2   = b;
      @(negedge clk);
      div_valid  = 1'b0;
      div_signed = ~sgn;
      div_src1   = $urandom;
      div_src2   = $urandom;
   endtask

   task automatic waitResult(output logic [31:0] q, output logic [31:0] r, output int lat);
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
      q = div_quotient;
      r = div_remainder;
   endtask

   task automatic releaseResult();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic runOp(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int elat);
      logic [31:0] q, r;
      int lat;
      checkOutput({name, " ready"}, {31'd0, div_ready}, 32'd1);
      applyStimulus(sgn, a, b);
      waitResult(q, r, lat);
      checkOutput({name, " quotient"}, q, eq);
      checkOutput({name, " remainder"}, r, er);
      checkOutput({name, " latency"}, lat, elat);
      releaseResult();
   endtask

   initial begin
      logic [31:0] eq, er, a, b, hq, hr;
      logic [31:0] q, r;
      int lat;
      bit seen;
      bit sgn;

      total = 0;
      bad   = 0;
      vecs[0] = '{1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, NORM_LAT};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD, 32'hFFFF_FFFF, NORM_LAT};
      vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, NORM_LAT};
      vecs[3] = '{1'b0, 32'h1234_5678,  32'h0000_0000,  32'hFFFF_FFFF, 32'h1234_5678, ZERO_LAT};
      vecs[4] = '{1'b1, 32'h1234_5678,  32'h0000_0000,  32'hFFFF_FFFF, 32'h1234_5678, ZERO_LAT};
      vecs[5] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, NORM_LAT};
      vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001, NORM_LAT};
      vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0000,  32'hFFFF_FFFF, 32'hFFFF_FFF9, ZERO_LAT};
      vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFF, 32'h0000_0000, NORM_LAT};

      resetn     = 1'b0;
      div_valid  = 1'b0;
      div_signed = 1'b0;
      div_src1   = 32'd0;
      div_src2   = 32'd0;
      div_cancel = 1'b0;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset quotient", div_quotient, 32'd0);
      checkOutput("reset remainder", div_remainder, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("reset div_ready", {31'd0, div_ready}, 32'd1);

      for (int i = 0; i < 9; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);
      end

      // Cancel priority over accept in IDLE.
      div_valid  = 1'b1;
      div_cancel = 1'b1;
      div_src1   = 32'd50;
      div_src2   = 32'd5;
      @(negedge clk);
      div_valid  = 1'b0;
      div_cancel = 1'b0;
      checkOutput("cancel beats accept", {31'd0, div_ready}, 32'd1);

      // Cancel at the 10th CALC cycle, then a fresh 9/3.
      applyStimulus(1'b0, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      div_cancel = 1'b1;
      @(negedge clk);
      div_cancel = 1'b0;
      checkOutput("cancel ready", {31'd0, div_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen |= out_valid;
         @(negedge clk);
      end
      checkOutput("cancel no out_valid", {31'd0, seen}, 32'd0);
      runOp("after cancel 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, NORM_LAT);

      // Backpressure: result held for 5 cycles while a stray request must be ignored.
      applyStimulus(1'b0, 32'd1000, 32'd9);
      waitResult(hq, hr, lat);
      checkOutput("hold latency", lat, NORM_LAT);
      checkOutput("hold quotient", hq, 32'd111);
      checkOutput("hold remainder", hr, 32'd1);
      div_valid = 1'b1;
      div_src1  = 32'd77;
      div_src2  = 32'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("hold%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         checkOutput($sformatf("hold%0d div_ready", i), {31'd0, div_ready}, 32'd0);
         checkOutput($sformatf("hold%0d quotient", i), div_quotient, hq);
         checkOutput($sformatf("hold%0d remainder", i), div_remainder, hr);
      end
      div_valid = 1'b0;
      releaseResult();
      checkOutput("release out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("release div_ready", {31'd0, div_ready}, 32'd1);

      // Cancel overrides a waiting result.
      applyStimulus(1'b0, 32'd20, 32'd4);
      waitResult(q, r, lat);
      checkOutput("done-cancel latency", lat, NORM_LAT);
      div_cancel = 1'b1;
      @(negedge clk);
      div_cancel = 1'b0;
      checkOutput("done-cancel out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("done-cancel div_ready", {31'd0, div_ready}, 32'd1);

      // Reset in the middle of CALC.
      applyStimulus(1'b1, 32'hFFFF_0000, 32'd17);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      checkOutput("midreset out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midreset quotient", div_quotient, 32'd0);
      checkOutput("midreset remainder", div_remainder, 32'd0);
      checkOutput("midreset div_ready", {31'd0, div_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen |= out_valid;
         @(negedge clk);
      end
      checkOutput("midreset no out_valid", {31'd0, seen}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = -$urandom_range(1, 255);
            3:       begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
            default: b = $urandom;
         endcase
         refDiv(sgn, a, b, eq, er);
         runOp($sformatf("rand%0d", i), sgn, a, b, eq, er, (b == 32'd0) ? ZERO_LAT : NORM_LAT);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have ports clk, input, 1, system clock; all state updates on the rising edge.
REQ-002 SHALL have ports resetn, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have ports div_valid, input, 1, request from the EX-stage ALU to start a divide.
REQ-004 SHALL have ports div_signed, input, 1, 1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
REQ-005 SHALL have ports div_src1, input, 32, dividend (rj).
REQ-006 SHALL have ports div_src2, input, 32, divisor (rk).
REQ-007 SHALL have ports div_cancel, input, 1, pipeline flush; aborts any operation.
REQ-008 SHALL have ports div_ready, output, 1, unit can accept a request this cycle.
REQ-009 SHALL have ports out_valid, output, 1, quotient/remainder valid.
REQ-010 SHALL have ports out_ready, input, 1, ALU consumes the result this cycle.
REQ-011 SHALL have ports div_quotient, output, 32, quotient.
REQ-012 SHALL have ports div_remainder, output, 32, remainder.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL drive div_ready = 1 only in IDLE, combinationally from state.
REQ-015 SHALL accept a request when div_valid & div_ready & ~div_cancel, latching operand magnitudes, quotient sign (src1[31]^src2[31] when signed) and remainder sign (src1[31] when signed); the FSM moves IDLE->CALC.
REQ-016 SHALL perform restoring division on 32-bit magnitudes, one quotient bit per cycle, MSB first, for exactly 32 CALC cycles, using a 6-bit iteration counter.
REQ-017 SHALL, after the 32nd iteration, apply sign fixups (negate quotient if its sign flag is set; negate remainder if its sign flag is set), register the results, and move CALC->DONE.
REQ-018 SHALL assert out_valid exactly 33 cycles after the accepting edge, for a normal operation.
REQ-019 SHALL assert out_valid only in DONE, and SHALL hold div_quotient/div_remainder stable while out_valid=1 and out_ready=0.
REQ-020 SHALL move DONE->IDLE on out_ready=1; the next request is accepted no earlier than the following cycle.
REQ-021 SHALL produce, for signed 0x80000000 / 0xFFFFFFFF, quotient 0x80000000 and remainder 0x00000000.
REQ-022 SHALL produce, for divisor 0, quotient 0xFFFFFFFF and remainder = div_src1, for both signed and unsigned operation.
REQ-023 SHALL, when div_cancel=1 in any state, go to IDLE next cycle with out_valid deasserted; cancel has priority over accept and over out_ready.
REQ-024 SHALL ignore div_valid outside IDLE; operand changes after acceptance have no effect.

Reset
REQ-025 SHALL, on resetn=0 at a clock edge, set state=IDLE, out_valid=0, div_quotient=0, div_remainder=0, and counter=0; div_ready=1 in the cycle after reset.
REQ-026 SHALL, on reset mid-CALC or in DONE, discard the operation with no out_valid pulse.

Configuration
REQ-027 SHALL, with DIV_ZERO_FAST_EN defined, detect divisor 0 at acceptance and go IDLE->DONE directly, asserting out_valid 1 cycle after the accepting edge with the REQ-022 values.
REQ-028 SHALL, without DIV_ZERO_FAST_EN, run a divide by 0 through the full 32 CALC cycles with 33-cycle latency and produce the REQ-022 values unchanged.

Verification
REQ-029 Unsigned 100/7, accepted at cycle 0 -> out_valid at cycle 33, quotient 0x0000000E, remainder 0x00000002.
REQ-030 Signed 0xFFFFFFF9 / 0x00000002 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-031 Divisor 0, dividend 0x12345678, both modes -> quotient 0xFFFFFFFF, remainder 0x12345678 at cycle 1 (macro defined) or cycle 33 (macro undefined).
REQ-032 div_cancel at cycle 10 of CALC -> div_ready=1 next cycle, out_valid never asserted; a new 9/3 request then completes with quotient 3, remainder 0.
REQ-033 out_ready held 0 for 5 cycles after out_valid -> outputs stable and div_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-034 resetn=0 mid-CALC -> out_valid=0, outputs=0, div_ready=1 the following cycle.
